// File: rtl/caliptra_prim_clock_div.sv
// caliptra_prim_clock_div
//   Programmable flop-based clock divider with 50% duty cycle. Ratio D (0 acts
//   as 1) gives a clk_o period of 2*D clk_i cycles. The ratio is changed via a
//   4-phase req/ack handshake and applied only at a clean clock boundary, so
//   clk_o never emits a runt pulse. In scan mode clk_o carries clk_i and all
//   divider state is frozen.
//
//   Optional build macro: CALIPTRA_PRIM_CLK_DIV_FULL_PERIOD_SWITCH_EN
//     defined   -> a pending ratio applies only on a falling toggle (whole periods)
//     undefined -> a pending ratio applies on any toggle (half-period boundary)
//   In both builds a divider stopped low is itself a valid boundary.
//
// Ports:
//   clk_i         source clock
//   rst_i         asynchronous active-high reset
//   scanmode_i    1 = clk_o follows clk_i, divider state frozen
//   en_i          divider run enable
//   div_req_i     ratio-change request (4-phase)
//   div_i         requested ratio, sampled when the request is accepted
//   div_ack_o     ratio-change acknowledge
//   active_div_o  ratio currently in effect
//   clk_o         divided clock
//
// State table (request FSM):
//   state | meaning
//   RUN   | idle, waiting for div_req_i
//   PEND  | ratio captured, waiting for a qualifying boundary
//   ACK   | ratio applied, div_ack_o high until div_req_i drops

// Scan-bypass clock mux. The FPGA global-buffer variant is not modelled here;
// both flavours reduce to the same behavioural mux.
module caliptra_prim_clock_mux2 #(
  parameter bit NoFpgaBufG = 1'b0
) (
  input  logic clk0_i,
  input  logic clk1_i,
  input  logic sel_i,
  output logic clk_o
);
  if (NoFpgaBufG) begin : g_no_bufg
    assign clk_o = sel_i ? clk1_i : clk0_i;
  end else begin : g_bufg
    assign clk_o = sel_i ? clk1_i : clk0_i;
  end
endmodule

module caliptra_prim_clock_div #(
  parameter int unsigned DivW       = 4,
  parameter int unsigned ResetDiv   = 2,
  parameter bit          NoFpgaBufG = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            scanmode_i,
  input  logic            en_i,
  input  logic            div_req_i,
  input  logic [DivW-1:0] div_i,
  output logic            div_ack_o,
  output logic [DivW-1:0] active_div_o,
  output logic            clk_o
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e          state;
  logic [DivW-1:0] cnt;
  logic [DivW-1:0] pend_div;
  logic            clk_q;

  logic [DivW-1:0] div_last;
  logic            running;
  logic            toggle;
  logic            stopped_low;
  logic            boundary;

  // Ratio 0 behaves as divide-by-1, so its terminal count is 0 as well.
  assign div_last = (active_div_o == '0) ? '0 : active_div_o - DivW'(1);

  // With en_i low the high phase still runs to completion; only a divider
  // sitting low is truly stopped.
  assign running     = en_i | clk_q;
  assign toggle      = running && (cnt == div_last);
  assign stopped_low = ~en_i & ~clk_q;

`ifdef CALIPTRA_PRIM_CLK_DIV_FULL_PERIOD_SWITCH_EN
  assign boundary = stopped_low | (toggle & clk_q);
`else
  assign boundary = stopped_low | toggle;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= RUN;
      cnt          <= '0;
      clk_q        <= 1'b0;
      pend_div     <= DivW'(ResetDiv);
      active_div_o <= DivW'(ResetDiv);
      div_ack_o    <= 1'b0;
    end else if (!scanmode_i) begin
      if (toggle) begin
        clk_q <= ~clk_q;
        cnt   <= '0;
      end else if (running) begin
        cnt <= cnt + DivW'(1);
      end

      case (state)
        RUN: begin
          if (div_req_i) begin
            pend_div <= div_i;
            state    <= PEND;
          end
        end
        PEND: begin
          // Same-cycle toggle keeps its edge; the new half-period starts
          // next cycle with the new ratio.
          if (boundary) begin
            active_div_o <= pend_div;
            cnt          <= '0;
            div_ack_o    <= 1'b1;
            state        <= ACK;
          end
        end
        ACK: begin
          if (!div_req_i) begin
            div_ack_o <= 1'b0;
            state     <= RUN;
          end
        end
        default: begin
          div_ack_o <= 1'b0;
          state     <= RUN;
        end
      endcase
    end
  end

  caliptra_prim_clock_mux2 #(
    .NoFpgaBufG(NoFpgaBufG)
  ) u_scan_mux (
    .clk0_i(clk_q),
    .clk1_i(clk_i),
    .sel_i (scanmode_i),
    .clk_o (clk_o)
  );

endmodule

// File: tb/tb_caliptra_prim_clock_div.sv
module tb_caliptra_prim_clock_div;

  localparam int RESET_DIV = 2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       scanmode_i = 1'b0;
  logic       en_i = 1'b1;
  logic       div_req_i = 1'b0;
  logic [3:0] div_i = 4'd0;
  logic       div_ack_o;
  logic [3:0] active_div_o;
  logic       clk_o;

  int total = 0;
  int bad   = 0;

  caliptra_prim_clock_div #(
    .DivW      (4),
    .ResetDiv  (RESET_DIV),
    .NoFpgaBufG(1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scanmode_i  (scanmode_i),
    .en_i        (en_i),
    .div_req_i   (div_req_i),
    .div_i       (div_i),
    .div_ack_o   (div_ack_o),
    .active_div_o(active_div_o),
    .clk_o       (clk_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: tracks the output level and the cycles left in the
  // current half-period, plus the handshake phase.
  int m_lvl, m_left, m_act, m_pend, m_ph, m_ack;

  function automatic int deff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic m_reset();
    m_lvl = 0; m_left = deff(RESET_DIV); m_act = RESET_DIV;
    m_pend = RESET_DIV; m_ph = 0; m_ack = 0;
  endtask

  task automatic m_step(input bit en, input bit req, input int div, input bit scan);
    bit run, edge_now, stop_low, bnd;
    if (scan) return;
    run      = en || (m_lvl == 1);
    edge_now = run && (m_left == 1);
    stop_low = !en && (m_lvl == 0);
`ifdef CALIPTRA_PRIM_CLK_DIV_FULL_PERIOD_SWITCH_EN
    bnd = stop_low || (edge_now && m_lvl == 1);
`else
    bnd = stop_low || edge_now;
`endif
    if (run) begin
      if (edge_now) begin
        m_lvl  = 1 - m_lvl;
        m_left = deff(m_act);
      end else begin
        m_left = m_left - 1;
      end
    end
    case (m_ph)
      0: if (req) begin m_pend = div; m_ph = 1; end
      1: if (bnd) begin m_act = m_pend; m_left = deff(m_act); m_ack = 1; m_ph = 2; end
      default: if (!req) begin m_ack = 0; m_ph = 0; end
    endcase
  endtask

  typedef struct {
    bit en;
    bit req;
    int div;
    bit exp_clk;
    bit exp_ack;
    int exp_act;
  } vec_t;

  function automatic vec_t mk(input bit en, input bit req, input int div,
                              input bit c, input bit a, input int act);
    vec_t v;
    v.en = en; v.req = req; v.div = div;
    v.exp_clk = c; v.exp_ack = a; v.exp_act = act;
    return v;
  endfunction

  vec_t vt[17];

  initial begin
    int n;
    bit pat[6];

    vt[0]  = mk(1, 0, 0, 0, 0, 2);
    vt[1]  = mk(1, 0, 0, 1, 0, 2);
    vt[2]  = mk(1, 1, 3, 1, 0, 2);  // capture 3 during high phase
    vt[3]  = mk(1, 1, 7, 0, 1, 3);  // falling toggle applies, div_i change ignored
    vt[4]  = mk(1, 1, 7, 0, 1, 3);
    vt[5]  = mk(1, 0, 0, 0, 0, 3);  // ack drops with req
    vt[6]  = mk(1, 0, 0, 1, 0, 3);  // low lasted 3 cycles
    vt[7]  = mk(1, 0, 0, 1, 0, 3);
    vt[8]  = mk(1, 0, 0, 1, 0, 3);
    vt[9]  = mk(1, 0, 0, 0, 0, 3);  // high lasted 3 cycles
    vt[10] = mk(0, 0, 0, 0, 0, 3);
    vt[11] = mk(0, 0, 0, 0, 0, 3);
    vt[12] = mk(0, 1, 0, 0, 0, 3);  // request 0 while stopped low
    vt[13] = mk(0, 1, 0, 0, 1, 0);  // applies at once
    vt[14] = mk(1, 0, 0, 1, 0, 0);
    vt[15] = mk(1, 0, 0, 0, 0, 0);
    vt[16] = mk(1, 0, 0, 1, 0, 0);

    // reset state
    #12;
    chk("rst_clk", clk_o, 0);
    chk("rst_ack", div_ack_o, 0);
    chk("rst_act", active_div_o, RESET_DIV);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 17; i++) begin
      en_i = vt[i].en; div_req_i = vt[i].req; div_i = 4'(vt[i].div);
      tick();
      chk($sformatf("vec%0d_clk", i), clk_o, vt[i].exp_clk);
      chk($sformatf("vec%0d_ack", i), div_ack_o, vt[i].exp_ack);
      chk($sformatf("vec%0d_act", i), active_div_o, vt[i].exp_act);
    end

    // switch to D=4
    div_req_i = 1'b1; div_i = 4'd4; n = 0;
    do begin tick(); n++; end while (!div_ack_o && n < 10);
    chk("d4_ack", div_ack_o, 1);
    chk("d4_act", active_div_o, 4);
    div_req_i = 1'b0;
    tick();
    chk("d4_ack_drop", div_ack_o, 0);
    n = 0;
    while (clk_o && n < 20) begin tick(); n++; end
    chk("d4_wait_low", clk_o, 0);
    n = 0;
    while (!clk_o && n < 20) begin tick(); n++; end
    chk("d4_wait_rise", clk_o, 1);

    // drop en_i mid high phase (cnt=1): two more high cycles, then held low
    tick();
    chk("en_hi_cnt1", clk_o, 1);
    en_i = 1'b0;
    tick(); chk("en_off_hi1", clk_o, 1);
    tick(); chk("en_off_hi2", clk_o, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("en_off_lo%0d", i), clk_o, 0);
    end
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("en_on_lo%0d", i), clk_o, 0);
    end
    tick(); chk("en_on_rise", clk_o, 1);

    // scan bypass freezes cnt=1 mid high phase
    tick(); chk("scan_pre", clk_o, 1);
    scanmode_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("scan_hi%0d", i), clk_o, 1);
      @(negedge clk_i); #1;
      chk($sformatf("scan_lo%0d", i), clk_o, 0);
    end
    chk("scan_act", active_div_o, 4);
    scanmode_i = 1'b0;
    tick(); chk("scan_res1", clk_o, 1);
    tick(); chk("scan_res2", clk_o, 1);
    tick(); chk("scan_res_fall", clk_o, 0);

    // reset while a D=5 change is pending
    div_req_i = 1'b1; div_i = 4'd5;
    tick();
    chk("pend_ack", div_ack_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_pend_act", active_div_o, RESET_DIV);
    chk("rst_pend_ack", div_ack_o, 0);
    chk("rst_pend_clk", clk_o, 0);
    @(negedge clk_i);
    div_req_i = 1'b0;
    rst_i = 1'b0;
    pat = '{0, 1, 1, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("post_rst_clk%0d", i), clk_o, pat[i]);
      chk($sformatf("post_rst_ack%0d", i), div_ack_o, 0);
      chk($sformatf("post_rst_act%0d", i), active_div_o, RESET_DIV);
    end

    // randomized run against the reference model
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b1; scanmode_i = 1'b0; div_req_i = 1'b0; div_i = 4'd0;
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk_i);
      m_step(en_i, div_req_i, int'(div_i), scanmode_i);
      #1;
      chk("rnd_clk", clk_o, scanmode_i ? 1 : m_lvl);
      chk("rnd_ack", div_ack_o, m_ack);
      chk("rnd_act", active_div_o, m_act);
      en_i       = ($urandom_range(0, 9) != 0);
      scanmode_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0) div_req_i = ~div_req_i;
      div_i = 4'($urandom_range(0, 15));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
